// File: rtl/wave_capture.sv
// Captures 256 audio samples into the half of the display RAM not being shown,
// arming on a positive-going zero crossing (or auto-timeout) and flipping halves in vblank.
module wave_capture #(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned AUTO_TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    new_sample_ready,
    input  logic [SAMPLE_WIDTH-1:0] new_sample_in,
    input  logic                    wave_display_idle,
    output logic [8:0]              write_address,
    output logic                    write_enable,
    output logic [7:0]              write_sample,
    output logic                    read_index
);

    localparam int unsigned TW      = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
    localparam int unsigned TO_LAST = (AUTO_TIMEOUT == 0) ? 0 : AUTO_TIMEOUT - 1;
    localparam bit          AUTO_EN = (AUTO_TIMEOUT != 0);

    generate
        if (SAMPLE_WIDTH < 8) begin : g_bad_width
            $error("wave_capture: SAMPLE_WIDTH must be >= 8");
        end
        if (SAMPLE_WIDTH > 8) begin : g_lsbs
            logic w_unused_lsbs;
            assign w_unused_lsbs = ^new_sample_in[SAMPLE_WIDTH-9:0];
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t        r_state;
    logic [7:0]    r_count;
    logic [TW-1:0] r_tcnt;
    logic          r_prev_neg;
    logic          r_idle_d;

    logic       w_msb;
    logic [7:0] w_conv;
    logic       w_crossing;
    logic       w_timeout;
    logic       w_idle_rise;

    // Top 8 bits of the signed sample re-biased to offset binary for the display.
    assign w_msb       = new_sample_in[SAMPLE_WIDTH-1];
    assign w_conv      = {~w_msb, new_sample_in[SAMPLE_WIDTH-2:SAMPLE_WIDTH-8]};
    assign w_crossing  = r_prev_neg & ~w_msb;
    assign w_timeout   = AUTO_EN && (r_tcnt == TW'(TO_LAST));
    assign w_idle_rise = wave_display_idle & ~r_idle_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_ARMED;
            r_count       <= 8'd0;
            r_tcnt        <= '0;
            r_prev_neg    <= 1'b0;
            r_idle_d      <= 1'b0;
            read_index    <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= 9'd0;
            write_sample  <= 8'd0;
        end else begin
            write_enable <= 1'b0;
            r_idle_d     <= wave_display_idle;
            if (new_sample_ready) begin
                r_prev_neg <= w_msb;
            end

            case (r_state)
                ST_ARMED: begin
                    if (new_sample_ready) begin
                        if (w_crossing || w_timeout) begin
                            write_enable  <= 1'b1;
                            write_address <= {~read_index, 8'd0};
                            write_sample  <= w_conv;
                            r_count       <= 8'd1;
                            r_tcnt        <= '0;
                            r_state       <= ST_ACTIVE;
                        end else begin
                            r_tcnt <= r_tcnt + TW'(1);
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (new_sample_ready) begin
                        write_enable  <= 1'b1;
                        write_address <= {~read_index, r_count};
                        write_sample  <= w_conv;
                        r_count       <= r_count + 8'd1;
                        if (r_count == 8'd255) begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // Flip only at the start of a blank period, never mid-blank.
                    if (w_idle_rise) begin
                        read_index <= ~read_index;
                        r_tcnt     <= '0;
                        r_state    <= ST_ARMED;
                    end
                end
                default: begin
                    r_state <= ST_ARMED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wave_capture.sv
// Bench for wave_capture: three instances (timeouts 1024, 4, 0) share one stimulus
// stream and are checked every cycle against a per-sample capture model.
module tb_wave_capture;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        rdy;
    logic [15:0] sin;
    logic        idle;

    logic [8:0] w_addr [NI];
    logic       w_we   [NI];
    logic [7:0] w_data [NI];
    logic       w_ri   [NI];

    always #5 clk = ~clk;

    wave_capture #(.SAMPLE_WIDTH(16), .AUTO_TIMEOUT(1024)) u_dut0 (
        .clk(clk), .reset(reset), .new_sample_ready(rdy), .new_sample_in(sin),
        .wave_display_idle(idle), .write_address(w_addr[0]), .write_enable(w_we[0]),
        .write_sample(w_data[0]), .read_index(w_ri[0]));
    wave_capture #(.SAMPLE_WIDTH(16), .AUTO_TIMEOUT(4)) u_dut1 (
        .clk(clk), .reset(reset), .new_sample_ready(rdy), .new_sample_in(sin),
        .wave_display_idle(idle), .write_address(w_addr[1]), .write_enable(w_we[1]),
        .write_sample(w_data[1]), .read_index(w_ri[1]));
    wave_capture #(.SAMPLE_WIDTH(16), .AUTO_TIMEOUT(0)) u_dut2 (
        .clk(clk), .reset(reset), .new_sample_ready(rdy), .new_sample_in(sin),
        .wave_display_idle(idle), .write_address(w_addr[2]), .write_enable(w_we[2]),
        .write_sample(w_data[2]), .read_index(w_ri[2]));

    int n_cmp  = 0;
    int n_fail = 0;
    int n_wr [NI];

    // Reference model: capture progress tracked per instance in plain integers.
    int to_lim [NI] = '{1024, 4, 0};
    bit m_cap    [NI];
    bit m_wait   [NI];
    int m_idx    [NI];
    int m_misses [NI];
    bit m_prevneg[NI];
    bit m_ri     [NI];
    bit m_idlep  [NI];
    bit exp_we   [NI];
    int exp_addr [NI];
    int exp_data [NI];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_cap[k] = 0; m_wait[k] = 0; m_idx[k] = 0; m_misses[k] = 0;
            m_prevneg[k] = 0; m_ri[k] = 0; m_idlep[k] = 0;
            exp_we[k] = 0; exp_addr[k] = 0; exp_data[k] = 0;
        end
    endtask

    task automatic emit(input int k, input int idx, input int v);
        exp_we[k]   = 1;
        exp_addr[k] = (m_ri[k] ? 0 : 256) + idx;
        exp_data[k] = ((v >>> 8) + 128) & 255;
    endtask

    // Predicts the outputs that follow the coming clock edge from the current inputs.
    task automatic model_step();
        int v;
        bit was_wait;
        bit trig;
        if (!reset) begin
            model_reset();
            return;
        end
        v = int'($signed(sin));
        for (int k = 0; k < NI; k++) begin
            exp_we[k] = 0;
            was_wait  = m_wait[k];
            if (was_wait && idle && !m_idlep[k]) begin
                m_ri[k]     = !m_ri[k];
                m_wait[k]   = 0;
                m_misses[k] = 0;
            end
            if (rdy && !was_wait) begin
                if (!m_cap[k]) begin
                    trig = (m_prevneg[k] && v >= 0) ||
                           (to_lim[k] != 0 && m_misses[k] == to_lim[k] - 1);
                    if (trig) begin
                        emit(k, 0, v);
                        m_idx[k] = 1; m_cap[k] = 1; m_misses[k] = 0;
                    end else begin
                        m_misses[k]++;
                    end
                end else begin
                    emit(k, m_idx[k], v);
                    m_idx[k]++;
                    if (m_idx[k] == 256) begin
                        m_cap[k]  = 0;
                        m_wait[k] = 1;
                    end
                end
            end
            if (rdy) m_prevneg[k] = (v < 0);
            m_idlep[k] = idle;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("we%0d", k), 32'(w_we[k]), 32'(exp_we[k]));
            if (exp_we[k]) begin
                chk($sformatf("addr%0d", k), 32'(w_addr[k]), 32'(exp_addr[k]));
                chk($sformatf("data%0d", k), 32'(w_data[k]), 32'(exp_data[k]));
            end
            chk($sformatf("ri%0d", k), 32'(w_ri[k]), 32'(m_ri[k]));
            if (w_we[k] === 1'b1) begin
                n_wr[k]++;
                chk($sformatf("half_sep%0d", k), 32'(w_addr[k][8] != w_ri[k]), 32'd1);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic strobe(input logic [15:0] s);
        rdy = 1'b1;
        sin = s;
        tick();
        rdy = 1'b0;
    endtask

    initial begin
        reset = 1'b0; rdy = 1'b0; sin = 16'h0; idle = 1'b1;
        for (int k = 0; k < NI; k++) n_wr[k] = 0;
        model_reset();

        // Reset state
        @(negedge clk);
        check_all();
        chk("rst_addr", 32'(w_addr[0]), 32'h0);
        chk("rst_data", 32'(w_data[0]), 32'h0);
        reset = 1'b1;
        tick();

        // Zero crossing on -5, -3, +2 with idle held high throughout
        strobe(16'hFFFB); tick();
        strobe(16'hFFFD); tick();
        strobe(16'h0002);
        chk("first_we", 32'(w_we[0]), 32'd1);
        chk("first_addr", 32'(w_addr[0]), 32'h100);
        chk("first_data", 32'(w_data[0]), 32'h80);

        // Remaining 255 samples with mixed gaps, then ignored strobes in WAIT
        for (int i = 0; i < 255; i++) begin
            strobe(16'h4000);
            if (i == 254) chk("last_addr", 32'(w_addr[0]), 32'h1FF);
            repeat ($urandom_range(0, 2)) tick();
        end
        for (int i = 0; i < 5; i++) strobe(16'(i * 1000 + 7));
        repeat (4) tick();
        chk("ri_hold", 32'(w_ri[0]), 32'd0);
        idle = 1'b0; tick();
        idle = 1'b1; tick();
        chk("ri_flip", 32'(w_ri[0]), 32'd1);

        // Second capture lands in the lower half
        strobe(16'hFF9C);
        strobe(16'h0064);
        chk("cap2_addr", 32'(w_addr[0]), 32'h000);

        // Random traffic: samples, strobe density and vblank toggling
        for (int i = 0; i < 3000; i++) begin
            rdy = ($urandom_range(0, 1) == 1);
            sin = 16'($urandom);
            if ($urandom_range(0, 39) == 0) idle = !idle;
            tick();
        end
        rdy = 1'b0;

        // Auto-trigger after 4 positive samples; timeout 0 never triggers
        reset = 1'b0; idle = 1'b0;
        tick();
        reset = 1'b1;
        n_wr[2] = 0;
        tick();
        for (int i = 0; i < 3; i++) strobe(16'd100);
        strobe(16'd100);
        chk("auto_we", 32'(w_we[1]), 32'd1);
        chk("auto_addr", 32'(w_addr[1]), 32'h100);
        for (int i = 0; i < 10000; i++) strobe(16'($urandom_range(0, 32767)));
        chk("no_auto_writes", 32'(n_wr[2]), 32'd0);

        // Asynchronous reset mid-capture at count 100
        reset = 1'b0; tick();
        reset = 1'b1; tick();
        strobe(16'hFFFF);
        strobe(16'h0001);
        for (int i = 0; i < 99; i++) strobe(16'($urandom_range(0, 32767)));
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_we", 32'(w_we[0]), 32'd0);
        chk("async_addr", 32'(w_addr[0]), 32'h0);
        chk("async_data", 32'(w_data[0]), 32'h0);
        tick();
        reset = 1'b1;
        tick();

        // Fresh crossing after reset, back-to-back strobes around the trigger
        strobe(16'hFFFF);
        strobe(16'h0001);
        chk("restart_addr", 32'(w_addr[0]), 32'h100);
        for (int i = 0; i < 10; i++) strobe(16'($urandom));
        chk("b2b_addr", 32'(w_addr[0]), 32'h10A);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
